// File: rtl/shk_rcv_cmd.sv
// shk_rcv_cmd -- receiving end of the narrow shake command link.
// Collects address beats (LSB-first, closed by an all-ones terminator), then
// data beats packed LSB-first into wide words written to a sync BRAM. After
// NB_IDLE_TO quiet cycles the command (address, word count) is reported on a
// wide shake port and held until the consumer acknowledges it.
// Optional feature macro: SHK_RCV_TERM_CHECK_EN -- a terminator beat that is
// not all ones flags bit0 and reports the command at once with no data.
module shk_rcv_cmd #(
  parameter int WD_LNK_DATA = 8,
  parameter int WD_LNK_ADDR = 8,
  parameter int WD_CMD_DATA = 32,
  parameter int WD_CMD_ADDR = 32,
  parameter int WD_SYNC_ADR = 8,
  parameter int NB_IDLE_TO  = 64,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_shk_lnk_valid,
  input  logic                   s_shk_lnk_msync,
  input  logic [WD_LNK_DATA-1:0] s_shk_lnk_mdata,
  input  logic [WD_LNK_ADDR-1:0] s_shk_lnk_maddr,
  output logic                   s_shk_lnk_ready,
  output logic                   s_shk_lnk_ssync,
  output logic [WD_LNK_DATA-1:0] s_shk_lnk_sdata,
  output logic [WD_LNK_ADDR-1:0] s_shk_lnk_saddr,
  output logic                   m_bram_sync_clk,
  output logic                   m_bram_sync_rst,
  output logic                   m_bram_sync_en,
  output logic                   m_bram_sync_we,
  output logic [WD_SYNC_ADR-1:0] m_bram_sync_addr,
  output logic [WD_CMD_DATA-1:0] m_bram_sync_din,
  output logic                   m_shk_cmd_valid,
  output logic [WD_CMD_ADDR-1:0] m_shk_cmd_maddr,
  output logic [WD_CMD_DATA-1:0] m_shk_cmd_mdata,
  input  logic                   m_shk_cmd_ready,
  output logic [WD_ERR_INFO-1:0] m_err_shk_info1
);

  localparam int NB_WORD = WD_CMD_DATA / WD_LNK_DATA;
  localparam int W_LANE  = (NB_WORD > 2) ? $clog2(NB_WORD) : 1;
  localparam int W_IDLE  = $clog2(NB_IDLE_TO + 1);
  localparam int W_WCNT  = WD_SYNC_ADR + 1;
  localparam int W_ABUF  = (NB_WORD - 1) * WD_LNK_DATA;

  localparam logic [W_LANE-1:0] LANE_LAST = W_LANE'(NB_WORD - 1);
  localparam logic [W_IDLE-1:0] IDLE_END  = W_IDLE'(NB_IDLE_TO);
  localparam logic [W_WCNT-1:0] WCNT_FULL = W_WCNT'(2 ** WD_SYNC_ADR);

  localparam int ERR_TERM  = 0;
  localparam int ERR_PART  = 1;
  localparam int ERR_OVF   = 2;
  localparam int ERR_PHASE = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_FLUSH, S_REPORT
  } state_t;

  state_t                   state_q, state_d;
  logic [W_ABUF-1:0]        addr_q, addr_d;
  logic [WD_CMD_DATA-1:0]   wbuf_q, wbuf_d;
  logic [W_LANE-1:0]        lane_q, lane_d;
  logic [W_IDLE-1:0]        idle_q, idle_d;
  logic [W_WCNT-1:0]        wcnt_q, wcnt_d;
  logic [WD_ERR_INFO-1:0]   err_q, err_d;
  logic                     ready_q, ready_d;
  logic                     bram_we_q, bram_we_d;
  logic [WD_SYNC_ADR-1:0]   bram_addr_q, bram_addr_d;
  logic [WD_CMD_DATA-1:0]   bram_din_q, bram_din_d;
  logic                     wr_req;
  logic [WD_CMD_DATA-1:0]   wr_word;
  logic                     term_bad;

`ifdef SHK_RCV_TERM_CHECK_EN
  assign term_bad = (s_shk_lnk_maddr != '1);
`else
  assign term_bad = 1'b0;
`endif

  // State register and all datapath flops; reset returns everything to 0.
  always_ff @(posedge i_sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_sys_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wbuf_q      <= '0;
      lane_q      <= '0;
      idle_q      <= '0;
      wcnt_q      <= '0;
      err_q       <= '0;
      ready_q     <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wbuf_q      <= wbuf_d;
      lane_q      <= lane_d;
      idle_q      <= idle_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  // Next-state logic: beat sequencing, idle timeout and report handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (s_shk_lnk_valid) state_d = S_ADDR;
      S_ADDR:   if (s_shk_lnk_valid && lane_q == LANE_LAST)
                  state_d = term_bad ? S_REPORT : S_DATA;
      S_DATA:   if (!s_shk_lnk_msync && idle_q == IDLE_END) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_REPORT;
      S_REPORT: if (m_shk_cmd_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded link and report strobes.
  always_comb begin
    s_shk_lnk_ssync = (state_q == S_ADDR) || (state_q == S_DATA);
    m_shk_cmd_valid = (state_q == S_REPORT);
  end

  // Datapath: address rebuild, lane packing, BRAM write request, error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    addr_d      = addr_q;
    wbuf_d      = wbuf_q;
    lane_d      = lane_q;
    idle_d      = idle_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    wr_req      = 1'b0;
    wr_word     = wbuf_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_shk_lnk_valid) begin
          ready_d = 1'b1;
          addr_d  = '0;
          addr_d[0 +: WD_LNK_DATA] = s_shk_lnk_maddr;
          lane_d  = W_LANE'(1);
          idle_d  = '0;
          wcnt_d  = '0;
          wbuf_d  = '0;
          err_d   = '0;
        end
      end
      S_ADDR: begin
        if (s_shk_lnk_msync) err_d[ERR_PHASE] = 1'b1;
        if (s_shk_lnk_valid) begin
          ready_d = 1'b1;
          if (lane_q == LANE_LAST) begin
            // Terminator beat: its value carries no address bits.
            lane_d = '0;
            wbuf_d = '0;
            idle_d = '0;
            if (term_bad) err_d[ERR_TERM] = 1'b1;
          end else begin
            addr_d[lane_q*WD_LNK_DATA +: WD_LNK_DATA] = s_shk_lnk_maddr;
            lane_d = lane_q + W_LANE'(1);
          end
        end
      end
      S_DATA: begin
        if (s_shk_lnk_valid) err_d[ERR_PHASE] = 1'b1;
        if (s_shk_lnk_msync) begin
          ready_d = 1'b1;
          idle_d  = '0;
          if (lane_q == LANE_LAST) begin
            wr_req = 1'b1;
            wr_word[lane_q*WD_LNK_DATA +: WD_LNK_DATA] = s_shk_lnk_mdata;
            wbuf_d = '0;
            lane_d = '0;
          end else begin
            wbuf_d[lane_q*WD_LNK_DATA +: WD_LNK_DATA] = s_shk_lnk_mdata;
            lane_d = lane_q + W_LANE'(1);
          end
        end else if (idle_q != IDLE_END) begin
          idle_d = idle_q + W_IDLE'(1);
        end
      end
      S_FLUSH: begin
        // Unfilled lanes are already zero because the buffer clears per word.
        if (lane_q != '0) begin
          wr_req          = 1'b1;
          err_d[ERR_PART] = 1'b1;
        end
        lane_d = '0;
        wbuf_d = '0;
      end
      default: ;
    endcase

    if (wr_req) begin
      if (wcnt_q == WCNT_FULL) begin
        err_d[ERR_OVF] = 1'b1;
      end else begin
        bram_we_d   = 1'b1;
        bram_addr_d = wcnt_q[WD_SYNC_ADR-1:0];
        bram_din_d  = wr_word;
        wcnt_d      = wcnt_q + W_WCNT'(1);
      end
    end
  end

  assign s_shk_lnk_ready  = ready_q;
  assign s_shk_lnk_sdata  = '0;
  assign s_shk_lnk_saddr  = '0;
  assign m_bram_sync_clk  = i_sys_clk;
  assign m_bram_sync_rst  = i_sys_rst;
  assign m_bram_sync_en   = bram_we_q;
  assign m_bram_sync_we   = bram_we_q;
  assign m_bram_sync_addr = bram_addr_q;
  assign m_bram_sync_din  = bram_din_q;
  assign m_shk_cmd_maddr  = WD_CMD_ADDR'(addr_q);
  assign m_shk_cmd_mdata  = WD_CMD_DATA'(wcnt_q);
  assign m_err_shk_info1  = err_q;

endmodule

// File: tb/tb_shk_rcv_cmd.sv
// Testbench for shk_rcv_cmd: directed scenarios plus randomized commands
// checked against a byte-level reference model of the command link.
module tb_shk_rcv_cmd;
  localparam int LD  = 8;
  localparam int CD  = 32;
  localparam int CA  = 32;
  localparam int SA  = 2;
  localparam int TO  = 64;
  localparam int EW  = 4;
  localparam int NW  = CD / LD;
  localparam int CAP = 2 ** SA;
  localparam int OW  = 5 + 2*LD + SA + 2*CD + CA + EW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          l_valid = 1'b0, l_msync = 1'b0;
  logic [LD-1:0] l_mdata = '0, l_maddr = '0;
  logic          l_ready, l_ssync;
  logic [LD-1:0] l_sdata, l_saddr;
  logic          b_clk, b_rst, b_en, b_we;
  logic [SA-1:0] b_addr;
  logic [CD-1:0] b_din;
  logic          c_valid;
  logic          c_ready = 1'b0;
  logic [CA-1:0] c_maddr;
  logic [CD-1:0] c_mdata;
  logic [EW-1:0] err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shk_rcv_cmd #(
    .WD_LNK_DATA(LD), .WD_LNK_ADDR(LD), .WD_CMD_DATA(CD), .WD_CMD_ADDR(CA),
    .WD_SYNC_ADR(SA), .NB_IDLE_TO(TO), .WD_ERR_INFO(EW)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .s_shk_lnk_valid(l_valid), .s_shk_lnk_msync(l_msync),
    .s_shk_lnk_mdata(l_mdata), .s_shk_lnk_maddr(l_maddr),
    .s_shk_lnk_ready(l_ready), .s_shk_lnk_ssync(l_ssync),
    .s_shk_lnk_sdata(l_sdata), .s_shk_lnk_saddr(l_saddr),
    .m_bram_sync_clk(b_clk), .m_bram_sync_rst(b_rst),
    .m_bram_sync_en(b_en), .m_bram_sync_we(b_we),
    .m_bram_sync_addr(b_addr), .m_bram_sync_din(b_din),
    .m_shk_cmd_valid(c_valid), .m_shk_cmd_maddr(c_maddr),
    .m_shk_cmd_mdata(c_mdata), .m_shk_cmd_ready(c_ready),
    .m_err_shk_info1(err)
  );

  // Monitor: ready pulses and BRAM writes, sampled on the falling edge.
  int            rdy_cnt = 0;
  logic [SA-1:0] wa_q[$];
  logic [CD-1:0] wd_q[$];
  always @(negedge clk) begin
    if (l_ready === 1'b1) rdy_cnt++;
    if (b_en === 1'b1 && b_we === 1'b1) begin
      wa_q.push_back(b_addr);
      wd_q.push_back(b_din);
    end
  end

  function automatic logic [OW-1:0] outs();
    return {l_ready, l_ssync, l_sdata, l_saddr, b_en, b_we, b_addr, b_din,
            c_valid, c_maddr, c_mdata, err};
  endfunction

  task automatic drive_beats(input bit is_addr, input logic [LD-1:0] b[$], input bit b2b);
    for (int i = 0; i < b.size(); i++) begin
      if (i == 0 || !b2b) begin
        if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
      end
      if (is_addr) begin l_valid = 1'b1; l_maddr = b[i]; end
      else begin l_msync = 1'b1; l_mdata = b[i]; end
      @(negedge clk);
      total++;
      if (l_ready !== 1'b1) begin
        bad++;
        $display("FAIL beat_ready %s beat %0d: got=%b want=1", is_addr ? "addr" : "data", i, l_ready);
      end
      if (!(b2b && i + 1 < b.size())) begin l_valid = 1'b0; l_msync = 1'b0; end
    end
  endtask

  task automatic stray(input bit is_valid);
    @(negedge clk);
    if (is_valid) begin l_valid = 1'b1; l_maddr = 8'h5A; end
    else begin l_msync = 1'b1; l_mdata = 8'hA5; end
    @(negedge clk);
    l_valid = 1'b0;
    l_msync = 1'b0;
  endtask

  task automatic wait_report(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 4*TO) begin
      if (c_valid === 1'b1) ok = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
  endtask

  // One full command: stimulus, reference model, report and BRAM checks.
  // inj: 0 none, 1 msync inside ADDR, 2 valid inside DATA (needs >=2 bytes).
  task automatic run_cmd(input string name, input logic [LD-1:0] ab[$], input logic [LD-1:0] db[$],
                         input int inj, input bit b2b, input bit early, input bit chk_lat);
    logic [CA-1:0] e_addr;
    logic [CD-1:0] e_words[$];
    logic [CD-1:0] word;
    logic [EW-1:0] e_err;
    logic [LD-1:0] head[$];
    logic [LD-1:0] tail[$];
    int n, nwords, e_cnt, r0, w0, lat;
    bit ok, tbad;
    n  = db.size();
    r0 = rdy_cnt;
    w0 = wa_q.size();
    tbad = 1'b0;
`ifdef SHK_RCV_TERM_CHECK_EN
    tbad = (ab[NW-1] !== 8'hFF);
`endif
    e_addr = '0;
    for (int i = 0; i < NW-1; i++) e_addr = e_addr | (CA'(ab[i]) << (LD*i));
    e_err = '0;
    if (inj == 1 || (inj == 2 && !tbad && n >= 2)) e_err[3] = 1'b1;
    e_cnt = 0;
    if (tbad) begin
      e_err[0] = 1'b1;
    end else begin
      nwords = (n + NW - 1) / NW;
      for (int w = 0; w < nwords; w++) begin
        word = '0;
        for (int l = 0; l < NW; l++)
          if (w*NW + l < n) word = word | (CD'(db[w*NW + l]) << (LD*l));
        e_words.push_back(word);
      end
      if (n % NW != 0) e_err[1] = 1'b1;
      if (nwords > CAP) e_err[2] = 1'b1;
      e_cnt = (nwords > CAP) ? CAP : nwords;
    end

    if (inj == 1) begin
      for (int i = 0; i < NW-1; i++) head.push_back(ab[i]);
      tail.push_back(ab[NW-1]);
      drive_beats(1'b1, head, b2b);
      stray(1'b0);
      drive_beats(1'b1, tail, b2b);
    end else begin
      drive_beats(1'b1, ab, b2b);
    end
    head = {};
    tail = {};
    if (!tbad && n > 0) begin
      if (inj == 2 && n >= 2) begin
        head.push_back(db[0]);
        for (int i = 1; i < n; i++) tail.push_back(db[i]);
        drive_beats(1'b0, head, b2b);
        stray(1'b1);
        drive_beats(1'b0, tail, b2b);
      end else begin
        drive_beats(1'b0, db, b2b);
      end
    end

    if (early) c_ready = 1'b1;
    wait_report(lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s report_timeout: got no valid within %0d cycles", name, 4*TO); end
    if (chk_lat) begin
      total++;
      if (lat != TO + 2) begin bad++; $display("FAIL %s latency: got=%0d want=%0d", name, lat, TO + 2); end
    end
    total++;
    if (c_maddr !== e_addr) begin bad++; $display("FAIL %s maddr: got=%h want=%h", name, c_maddr, e_addr); end
    total++;
    if (c_mdata !== CD'(e_cnt)) begin bad++; $display("FAIL %s mdata: got=%0d want=%0d", name, c_mdata, e_cnt); end
    total++;
    if (err !== e_err) begin bad++; $display("FAIL %s err: got=%b want=%b", name, err, e_err); end
    if (!early) c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    total++;
    if (c_valid !== 1'b0) begin bad++; $display("FAIL %s valid_drop: got=%b want=0", name, c_valid); end
    total++;
    if (wa_q.size() - w0 != e_cnt) begin
      bad++;
      $display("FAIL %s write_count: got=%0d want=%0d", name, wa_q.size() - w0, e_cnt);
    end
    for (int i = 0; i < e_cnt && w0 + i < wa_q.size(); i++) begin
      total++;
      if (wa_q[w0+i] !== SA'(i) || wd_q[w0+i] !== e_words[i]) begin
        bad++;
        $display("FAIL %s write%0d: got=%0d:%h want=%0d:%h", name, i, wa_q[w0+i], wd_q[w0+i], i, e_words[i]);
      end
    end
    if (inj == 0) begin
      total++;
      if (rdy_cnt - r0 != NW + (tbad ? 0 : n)) begin
        bad++;
        $display("FAIL %s ready_pulses: got=%0d want=%0d", name, rdy_cnt - r0, NW + (tbad ? 0 : n));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL reset_outputs: got=%h want=0", outs()); end
    total++;
    if (b_rst !== 1'b1) begin bad++; $display("FAIL reset_bram_rst: got=%b want=1", b_rst); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (b_rst !== 1'b0 || outs() !== '0) begin
      bad++;
      $display("FAIL reset_release: got rst=%b outs=%h want rst=0 outs=0", b_rst, outs());
    end
  endtask

  task automatic test_basic();
    logic [LD-1:0] ab[$] = '{8'h56, 8'h34, 8'h12, 8'hFF};
    logic [LD-1:0] db[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int w0 = wd_q.size();
    run_cmd("basic", ab, db, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (wd_q.size() < w0 + 2 || wd_q[w0] !== 32'h44332211 || wd_q[w0+1] !== 32'h88776655) begin
      bad++;
      $display("FAIL basic_words: got %0d writes, want 44332211 88776655", wd_q.size() - w0);
    end
  endtask

  task automatic test_addr_only();
    logic [LD-1:0] ab[$] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    logic [LD-1:0] db[$];
    run_cmd("addr_only", ab, db, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_partial();
    logic [LD-1:0] ab[$] = '{8'h01, 8'h02, 8'h03, 8'hFF};
    logic [LD-1:0] db[$] = '{8'hAA, 8'hBB, 8'hCC};
    int w0 = wd_q.size();
    run_cmd("partial", ab, db, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (wd_q.size() < w0 + 1 || wd_q[w0] !== 32'h00CCBBAA) begin
      bad++;
      $display("FAIL partial_word: got %0d writes, want one write of 00ccbbaa", wd_q.size() - w0);
    end
  endtask

  task automatic test_terminator();
    logic [LD-1:0] ab[$] = '{8'h11, 8'h22, 8'h33, 8'h7E};
    logic [LD-1:0] db[$] = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_cmd("terminator", ab, db, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [LD-1:0] ab[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hFF};
    logic [LD-1:0] db[$];
    for (int i = 1; i <= 20; i++) db.push_back(LD'(i));
    run_cmd("overflow", ab, db, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_phase();
    logic [LD-1:0] ab[$] = '{8'h9A, 8'hBC, 8'hDE, 8'hFF};
    logic [LD-1:0] db[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_cmd("msync_in_addr", ab, db, 1, 1'b0, 1'b0, 1'b0);
    run_cmd("valid_in_data", ab, db, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [LD-1:0] ab[$] = '{8'hC3, 8'h5A, 8'h0F, 8'hFF};
    logic [LD-1:0] db[$] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87};
    run_cmd("back_to_back", ab, db, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [LD-1:0] ab[$] = '{8'h21, 8'h43, 8'h65, 8'hFF};
    logic [LD-1:0] db[$] = '{8'h01, 8'h02};
    logic [LD-1:0] db2[$] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h77};
    drive_beats(1'b1, ab, 1'b0);
    drive_beats(1'b0, db, 1'b0);
    total++;
    if (l_ssync !== 1'b1) begin bad++; $display("FAIL mid_ssync: got=%b want=1", l_ssync); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== '0) begin bad++; $display("FAIL mid_reset_outputs: got=%h want=0", outs()); end
    rst = 1'b0;
    run_cmd("after_reset", ab, db2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [LD-1:0] ab[$];
    logic [LD-1:0] db[$];
    int n, inj;
    for (int k = 0; k < 8; k++) begin
      ab = {};
      db = {};
      for (int i = 0; i < NW-1; i++) ab.push_back(LD'($urandom));
      ab.push_back(8'hFF);
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) db.push_back(LD'($urandom));
      inj = (n >= 2) ? $urandom_range(0, 2) : $urandom_range(0, 1);
      run_cmd($sformatf("rand%0d", k), ab, db, inj, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_only();
    test_partial();
    test_terminator();
    test_overflow();
    test_wrong_phase();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
